// File: rtl/time_pkg.sv
// Shared constants and types for the time-of-day counter and its set-mode controller.
// Mode encoding is also the FSM state encoding of time_set_controller.
package time_pkg;

   localparam logic [1:0] MODE_RUN   = 2'd0;
   localparam logic [1:0] MODE_SET_H = 2'd1;
   localparam logic [1:0] MODE_SET_M = 2'd2;

   localparam int SEC_MOD = 60;
   localparam int MIN_MOD = 60;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   typedef struct packed {
      logic [HOUR_W-1:0] hours;
      logic [MIN_W-1:0]  minutes;
      logic [SEC_W-1:0]  seconds;
   } time_t;

endpackage

// File: rtl/mod_counter.sv
// Wrapping modulo-MOD counter; any value >= MOD-1 wraps to 0 on the next increment.
// Latency: value updates one clk after inc/clr; carry is combinational (inc at the wrap value).
// Backpressure: none, inc is taken every cycle it is asserted; clr has priority over inc.
module mod_counter #(
   parameter int MOD = 60,
   parameter int W   = 6
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] value,
   output logic         carry
);

   logic at_wrap;

   // Out-of-range values behave like the wrap value so the counter self-heals.
   assign at_wrap = (value >= W'(MOD - 1));
   assign carry   = inc & at_wrap;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc) begin
         value <= at_wrap ? '0 : value + W'(1);
      end
   end

endmodule

// File: rtl/time_set_controller.sv
// HH:MM:SS time-of-day sequencer with button-driven set mode, blink phase and set-mode timeout.
// Latency: every output is registered; an input sampled at edge N shows after edge N.
// Backpressure: none, strobes and button pulses are consumed in the cycle they arrive.
module time_set_controller
   import time_pkg::*;
#(
   parameter int HOURS_MOD = 24,
   parameter int TIMEOUT_S = 30
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sec_tick,
   input  logic              mode_btn,
   input  logic              inc_btn,
   output logic [HOUR_W-1:0] hours,
   output logic [MIN_W-1:0]  minutes,
   output logic [SEC_W-1:0]  seconds,
   output logic [1:0]        mode,
   output logic              blink,
   output logic              day_tick
);

   localparam int TW = $clog2(TIMEOUT_S + 1);

   logic          is_run;
   logic          is_set_h;
   logic          is_set_m;
   logic          user_inc;
   logic          sec_inc;
   logic          sec_clr;
   logic          min_inc;
   logic          hr_inc;
   logic          sec_carry;
   logic          min_carry;
   logic          hr_carry;
   logic [TW-1:0] tmo_cnt;
   time_t         now;

   assign is_run   = (mode == MODE_RUN);
   assign is_set_h = (mode == MODE_SET_H);
   assign is_set_m = (mode == MODE_SET_M);

   // mode_btn outranks both inc_btn and a coincident sec_tick.
   assign user_inc = inc_btn & ~mode_btn;
   assign sec_inc  = is_run & sec_tick & ~mode_btn;
   assign sec_clr  = is_run & mode_btn;
   assign min_inc  = sec_carry | (is_set_m & user_inc);
   // Minute wrap only carries while running; a set-mode wrap leaves hours alone.
   assign hr_inc   = (is_run & min_carry) | (is_set_h & user_inc);

   mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (sec_clr),
      .inc     (sec_inc),
      .value   (now.seconds),
      .carry   (sec_carry)
   );

   mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (1'b0),
      .inc     (min_inc),
      .value   (now.minutes),
      .carry   (min_carry)
   );

   mod_counter #(.MOD(HOURS_MOD), .W(HOUR_W)) u_hr (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (1'b0),
      .inc     (hr_inc),
      .value   (now.hours),
      .carry   (hr_carry)
   );

   assign hours   = now.hours;
   assign minutes = now.minutes;
   assign seconds = now.seconds;

   // Registered alongside the counters so it lines up with the 00:00:00 display.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         day_tick <= 1'b0;
      end else begin
         day_tick <= is_run & hr_carry;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode    <= MODE_RUN;
         blink   <= 1'b0;
         tmo_cnt <= '0;
      end else if (mode_btn) begin
         tmo_cnt <= '0;
         case (mode)
            MODE_RUN: begin
               mode  <= MODE_SET_H;
               blink <= 1'b1;
            end
            MODE_SET_H: begin
               mode  <= MODE_SET_M;
               blink <= 1'b1;
            end
            default: begin
               mode  <= MODE_RUN;
               blink <= 1'b0;
            end
         endcase
      end else if (is_set_h || is_set_m) begin
         if (inc_btn) begin
            blink   <= 1'b1;
            tmo_cnt <= '0;
         end else if (sec_tick) begin
            if (tmo_cnt >= TW'(TIMEOUT_S - 1)) begin
               mode    <= MODE_RUN;
               blink   <= 1'b0;
               tmo_cnt <= '0;
            end else begin
               blink   <= ~blink;
               tmo_cnt <= tmo_cnt + TW'(1);
            end
         end
      end else if (!is_run) begin
         // Unused encoding falls back to RUN.
         mode    <= MODE_RUN;
         blink   <= 1'b0;
         tmo_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller: rollover, async reset, set modes, timeout, simultaneous events.
module tb_time_set_controller;

   logic       clk;
   logic       reset_n;
   logic       sec_tick;
   logic       mode_btn;
   logic       inc_btn;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic [1:0] mode;
   logic       blink;
   logic       day_tick;

   int tests;
   int fails;

   time_set_controller #(.HOURS_MOD(24), .TIMEOUT_S(30)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .sec_tick (sec_tick),
      .mode_btn (mode_btn),
      .inc_btn  (inc_btn),
      .hours    (hours),
      .minutes  (minutes),
      .seconds  (seconds),
      .mode     (mode),
      .blink    (blink),
      .day_tick (day_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One pulse cycle followed by one idle cycle; returns on a falling edge.
   task automatic drive(input logic m, input logic i, input logic s);
      @(negedge clk);
      mode_btn = m;
      inc_btn  = i;
      sec_tick = s;
      @(negedge clk);
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      sec_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b1);
   endtask

   task automatic incs(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      do_reset();
      drive(1'b1, 1'b0, 1'b0);
      incs(h);
      drive(1'b1, 1'b0, 1'b0);
      incs(m);
      drive(1'b1, 1'b0, 1'b0);
      ticks(s);
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (hours !== 5'd0 || minutes !== 6'd0 || seconds !== 6'd0 || mode !== 2'd0
          || blink !== 1'b0 || day_tick !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: got %0d:%0d:%0d mode=%0d blink=%b day=%b, want 0:0:0 mode=0 blink=0 day=0",
                  hours, minutes, seconds, mode, blink, day_tick);
      end
   endtask

   task automatic test_rollover();
      set_time(23, 59, 58);
      tests++;
      if (hours !== 5'd23 || minutes !== 6'd59 || seconds !== 6'd58 || mode !== 2'd0) begin
         fails++;
         $display("FAIL preset_235958: got %0d:%0d:%0d mode=%0d, want 23:59:58 mode=0",
                  hours, minutes, seconds, mode);
      end
      ticks(1);
      tests++;
      if (hours !== 5'd23 || minutes !== 6'd59 || seconds !== 6'd59 || day_tick !== 1'b0) begin
         fails++;
         $display("FAIL tick_235959: got %0d:%0d:%0d day=%b, want 23:59:59 day=0",
                  hours, minutes, seconds, day_tick);
      end
      drive(1'b0, 1'b0, 1'b1);
      // drive() returns one idle cycle after the tick edge, so look back at that edge's cycle.
      tests++;
      if (hours !== 5'd0 || minutes !== 6'd0 || seconds !== 6'd0) begin
         fails++;
         $display("FAIL day_wrap: got %0d:%0d:%0d, want 0:0:0", hours, minutes, seconds);
      end
   endtask

   // Checks day_tick cycle by cycle around the midnight wrap.
   task automatic test_day_tick_pulse();
      set_time(23, 59, 59);
      @(negedge clk);
      sec_tick = 1'b1;
      @(negedge clk);
      sec_tick = 1'b0;
      tests++;
      if (day_tick !== 1'b1 || hours !== 5'd0 || minutes !== 6'd0 || seconds !== 6'd0) begin
         fails++;
         $display("FAIL day_tick_high: got day=%b at %0d:%0d:%0d, want day=1 at 0:0:0",
                  day_tick, hours, minutes, seconds);
      end
      @(negedge clk);
      tests++;
      if (day_tick !== 1'b0) begin
         fails++;
         $display("FAIL day_tick_one_cycle: got day=%b, want 0", day_tick);
      end
   endtask

   task automatic test_async_reset();
      set_time(23, 59, 58);
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if (hours !== 5'd0 || minutes !== 6'd0 || seconds !== 6'd0 || mode !== 2'd0 || blink !== 1'b0) begin
         fails++;
         $display("FAIL async_reset_run: got %0d:%0d:%0d mode=%0d blink=%b, want 0:0:0 mode=0 blink=0",
                  hours, minutes, seconds, mode, blink);
      end
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0);
      incs(2);
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if (hours !== 5'd0 || mode !== 2'd0 || blink !== 1'b0) begin
         fails++;
         $display("FAIL async_reset_set: got hours=%0d mode=%0d blink=%b, want 0 0 0", hours, mode, blink);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_set_hours();
      set_time(10, 15, 42);
      drive(1'b1, 1'b0, 1'b0);
      tests++;
      if (mode !== 2'd1 || seconds !== 6'd0 || blink !== 1'b1 || hours !== 5'd10 || minutes !== 6'd15) begin
         fails++;
         $display("FAIL enter_set_h: got mode=%0d %0d:%0d:%0d blink=%b, want mode=1 10:15:0 blink=1",
                  mode, hours, minutes, seconds, blink);
      end
      incs(3);
      tests++;
      if (hours !== 5'd13 || minutes !== 6'd15) begin
         fails++;
         $display("FAIL inc_hours: got %0d:%0d, want 13:15", hours, minutes);
      end
      ticks(1);
      tests++;
      if (blink !== 1'b0 || hours !== 5'd13 || minutes !== 6'd15 || seconds !== 6'd0 || mode !== 2'd1) begin
         fails++;
         $display("FAIL set_tick_frozen: got blink=%b %0d:%0d:%0d mode=%0d, want blink=0 13:15:0 mode=1",
                  blink, hours, minutes, seconds, mode);
      end
      ticks(1);
      tests++;
      if (blink !== 1'b1 || seconds !== 6'd0) begin
         fails++;
         $display("FAIL set_tick_toggle: got blink=%b sec=%0d, want blink=1 sec=0", blink, seconds);
      end
   endtask

   task automatic test_set_minutes();
      drive(1'b1, 1'b0, 1'b0);
      tests++;
      if (mode !== 2'd2 || blink !== 1'b1) begin
         fails++;
         $display("FAIL enter_set_m: got mode=%0d blink=%b, want mode=2 blink=1", mode, blink);
      end
      incs(44);
      tests++;
      if (minutes !== 6'd59 || hours !== 5'd13) begin
         fails++;
         $display("FAIL inc_min_59: got %0d:%0d, want 13:59", hours, minutes);
      end
      incs(1);
      tests++;
      if (minutes !== 6'd0 || hours !== 5'd13) begin
         fails++;
         $display("FAIL min_wrap_no_carry: got %0d:%0d, want 13:0", hours, minutes);
      end
      drive(1'b1, 1'b0, 1'b0);
      tests++;
      if (mode !== 2'd0 || blink !== 1'b0 || seconds !== 6'd0) begin
         fails++;
         $display("FAIL exit_to_run: got mode=%0d blink=%b sec=%0d, want 0 0 0", mode, blink, seconds);
      end
      ticks(1);
      tests++;
      if (seconds !== 6'd1 || minutes !== 6'd0 || hours !== 5'd13) begin
         fails++;
         $display("FAIL resume_count: got %0d:%0d:%0d, want 13:0:1", hours, minutes, seconds);
      end
   endtask

   task automatic test_timeout();
      drive(1'b1, 1'b0, 1'b0);
      ticks(29);
      tests++;
      if (mode !== 2'd1) begin
         fails++;
         $display("FAIL timeout_early: got mode=%0d after 29 ticks, want 1", mode);
      end
      ticks(1);
      tests++;
      if (mode !== 2'd0 || blink !== 1'b0 || hours !== 5'd13 || minutes !== 6'd0 || seconds !== 6'd0) begin
         fails++;
         $display("FAIL timeout_exit: got mode=%0d blink=%b %0d:%0d:%0d, want mode=0 blink=0 13:0:0",
                  mode, blink, hours, minutes, seconds);
      end
   endtask

   task automatic test_hour_wrap();
      do_reset();
      drive(1'b1, 1'b0, 1'b0);
      incs(23);
      tests++;
      if (hours !== 5'd23) begin
         fails++;
         $display("FAIL inc_hours_23: got %0d, want 23", hours);
      end
      incs(1);
      tests++;
      if (hours !== 5'd0 || minutes !== 6'd0) begin
         fails++;
         $display("FAIL hour_wrap_set: got %0d:%0d, want 0:0", hours, minutes);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      drive(1'b1, 1'b0, 1'b0);
      incs(5);
      drive(1'b1, 1'b1, 1'b0);
      tests++;
      if (mode !== 2'd2 || hours !== 5'd5 || minutes !== 6'd0) begin
         fails++;
         $display("FAIL mode_beats_inc: got mode=%0d %0d:%0d, want mode=2 5:0", mode, hours, minutes);
      end
      drive(1'b1, 1'b0, 1'b0);
      ticks(30);
      drive(1'b0, 1'b1, 1'b0);
      tests++;
      if (seconds !== 6'd30 || hours !== 5'd5 || minutes !== 6'd0 || mode !== 2'd0) begin
         fails++;
         $display("FAIL inc_ignored_run: got %0d:%0d:%0d mode=%0d, want 5:0:30 mode=0",
                  hours, minutes, seconds, mode);
      end
      drive(1'b1, 1'b0, 1'b1);
      tests++;
      if (mode !== 2'd1 || seconds !== 6'd0 || blink !== 1'b1) begin
         fails++;
         $display("FAIL mode_beats_tick: got mode=%0d sec=%0d blink=%b, want 1 0 1", mode, seconds, blink);
      end
      ticks(1);
      drive(1'b0, 1'b1, 1'b1);
      tests++;
      if (hours !== 5'd6 || blink !== 1'b1 || mode !== 2'd1 || seconds !== 6'd0) begin
         fails++;
         $display("FAIL inc_with_tick: got hours=%0d blink=%b mode=%0d sec=%0d, want 6 1 1 0",
                  hours, blink, mode, seconds);
      end
      // Counter was zeroed by the inc, so the 30th tick is the one paired with mode_btn.
      ticks(29);
      drive(1'b1, 1'b0, 1'b1);
      tests++;
      if (mode !== 2'd2 || blink !== 1'b1 || hours !== 5'd6) begin
         fails++;
         $display("FAIL mode_beats_timeout: got mode=%0d blink=%b hours=%0d, want 2 1 6", mode, blink, hours);
      end
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      reset_n  = 1'b0;
      sec_tick = 1'b0;
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      test_reset();
      test_rollover();
      test_day_tick_pulse();
      test_async_reset();
      test_set_hours();
      test_set_minutes();
      test_timeout();
      test_hour_wrap();
      test_simultaneous();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Sequences the HH:MM:SS time-of-day registers of the time counter.
- Advances time on a one-cycle seconds strobe and generates the cascaded minute, hour and day carries.
- Provides a user set mode (set hours, then set minutes) driven by two pre-debounced button pulses, with blink and timeout support for the display.
- Sits between the tick generators / button conditioner and the display driver.

Parameters:
- HOURS_MOD, 24, hour wrap modulus (12 or 24).
- TIMEOUT_S, 30, number of sec_tick strobes without a button press before set mode auto-exits to RUN.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sec_tick  input  1  one-cycle strobe, once per second.
- mode_btn  input  1  one-cycle pulse, debounced upstream; cycles the mode.
- inc_btn  input  1  one-cycle pulse, debounced upstream; increments the selected field.
- hours  output  5  binary hours, 0..HOURS_MOD-1.
- minutes  output  6  binary minutes, 0..59.
- seconds  output  6  binary seconds, 0..59.
- mode  output  2  0=RUN, 1=SET_H, 2=SET_M.
- blink  output  1  display blank phase for the selected field; always 0 in RUN.
- day_tick  output  1  one-cycle pulse on the wrap from HOURS_MOD-1:59:59 to 00:00:00.

Behaviour:
- Reset: asynchronous, active-low.
  - Asserting reset_n low at any time, including mid-set, forces hours=minutes=seconds=0, mode=RUN, blink=0, day_tick=0 and timeout counter=0.
  - Release is synchronous to the next clk edge.
- All outputs are registered. An input sampled at edge N is reflected in the outputs after edge N.
- RUN, on sec_tick:
  - seconds+1. At 59 it wraps to 0 and carries minutes+1.
  - minutes 59 wraps to 0 and carries hours+1.
  - hours HOURS_MOD-1 wraps to 0 and pulses day_tick for exactly the same cycle the registers show 00:00:00.
  - inc_btn is ignored in RUN.
- FSM transitions on mode_btn: RUN -> SET_H -> SET_M -> RUN.
  - Entering SET_H clears seconds to 0 and blink to 1, and zeroes the timeout counter.
  - SET_H -> SET_M sets blink to 1 and zeroes the timeout counter.
  - SET_M -> RUN clears blink, and counting resumes from seconds=0.
- SET_H / SET_M:
  - sec_tick does not advance time. It toggles blink and increments the timeout counter.
  - inc_btn adds 1 to the selected field, wrapping with no carry: hours at HOURS_MOD-1 -> 0; minutes 59 -> 0 with hours unchanged.
  - inc_btn also zeroes the timeout counter and forces blink=1.
- Timeout: when the counter reaches TIMEOUT_S on a sec_tick, mode returns to RUN and blink=0. Field values are kept and seconds remain 0.
- Simultaneous events:
  - mode_btn and inc_btn in the same cycle: mode_btn wins and inc_btn is discarded.
  - mode_btn and sec_tick in RUN: the transition to SET_H wins, the tick is discarded and seconds=0.
  - inc_btn and sec_tick in a set state: increment applied, blink forced to 1, timeout counter zeroed.
  - mode_btn and timeout expiry in the same cycle: mode_btn transition wins.
- day_tick is never asserted in a set state.
- Field width rules: counters never hold out-of-range values. Any out-of-range state is treated as the wrap value on the next increment.

Decomposition:
- Shared package time_pkg holds:
  - mode encoding constants (MODE_RUN=0, MODE_SET_H=1, MODE_SET_M=2);
  - SEC_MOD=60 and MIN_MOD=60;
  - field width constants (HOUR_W=5, MIN_W=6, SEC_W=6).
- One sub-module, mod_counter, instantiated three times. It is a parameterised-modulus wrapping counter with the following signals:
  - inputs: clk, reset_n, clr, inc;
  - outputs: value and a combinational carry (inc at modulus-1).
- The FSM, blink and timeout logic live in time_set_controller.

Test Plan:
- Reset 23:59:58 state mid-run via reset_n=0 -> all outputs 0, mode=0, immediately (asynchronous, before the next clk edge).
- From 23:59:58 in RUN apply 2 sec_tick -> 23:59:59, then 00:00:00 with day_tick=1 for exactly one cycle.
- In RUN at 10:15:42 pulse mode_btn -> mode=1, seconds=0, blink=1. Then 3 inc_btn -> hours=13. sec_tick toggles blink while time stays frozen.
- In SET_M at minutes=59: inc_btn -> minutes=0, hours unchanged. mode_btn -> mode=0, blink=0, and the next sec_tick gives seconds=1.
- In SET_H with no buttons, 30 sec_tick -> mode=0 on the 30th tick, with hours and minutes preserved.
- mode_btn+inc_btn same cycle in SET_H at hours=5 -> mode=2, hours=5. mode_btn+sec_tick in RUN at seconds=30 -> mode=1, seconds=0.
